reduce_vector_issuer: RTL
=========================

# reduce_vector_issuer

Initiator side of the vector-reduction interface: accepts a reduction command and a stream of scalar elements, assembles them into the N-element operand array, pulses `set` into `reduce_vector_alu`, waits for `done`, and returns the scalar result through a valid/ready port. It sits between the host-facing command/data FIFOs and the reduce ALU, so the host never drives the ALU's parallel operand bus directly.

## Interface
- BITS, 8, element and result width
- N, 8, operand array depth (max vector length), 2..255
- TIMEOUT, 255, max cycles to wait for `alu_done` before aborting, ≥ 2
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- cmd_sel  in  2  reduction opcode, forwarded unchanged to ALU `sel`
- cmd_valid  in  1  command present
- cmd_ready  out  1  issuer can accept a command
- s_data  in  BITS  element value
- s_valid  in  1  element present
- s_last  in  1  element is final element of vector
- s_ready  out  1  issuer accepts element
- alu_in  out  BITS×N (unpacked [N-1:0])  operand array to ALU `in`
- alu_in_len  out  8  index of last valid element (count − 1) to ALU `in_len`
- alu_sel  out  2  to ALU `sel`
- alu_set  out  1  one-cycle start pulse to ALU `set`
- alu_en  out  1  ALU enable
- alu_out  in  BITS  ALU result
- alu_done  in  1  ALU result valid
- res_data  out  BITS  reduction result
- res_err  out  1  result aborted by timeout (res_data = 0)
- res_valid  out  1  result present
- res_ready  in  1  consumer accepts result

## Operation
- FSM states: IDLE, LOAD, ISSUE, WAIT, RESP.
- IDLE: cmd_ready=1. On cmd_valid: latch cmd_sel into alu_sel, clear all alu_in elements to 0, clear element count, → LOAD.
- LOAD: s_ready=1. Each beat with s_valid&s_ready writes s_data to alu_in[count], count++. Load ends on the beat with s_last=1 or the beat writing index N−1 (whichever first); s_last on a beat beyond that is never seen because s_ready drops. → ISSUE.
- ISSUE: alu_in_len = count − 1 (held stable from here through WAIT); alu_set=1 for exactly this cycle. → WAIT; timeout counter cleared.
- WAIT: alu_done ignored in first WAIT cycle (stale done from prior op). From second WAIT cycle, alu_done=1 captures alu_out into res_data, res_err=0, → RESP. If counter reaches TIMEOUT with no done: res_data=0, res_err=1, → RESP.
- RESP: res_valid=1, res_data/res_err stable until res_valid&res_ready; then → IDLE.
- alu_en = 1 in ISSUE and WAIT, else 0.
- alu_in and alu_sel hold their values outside LOAD (no clearing on RESP).
- cmd_ready=1 only in IDLE; s_ready=1 only in LOAD.

## Timing
- Reset (rst_n=0, async): state=IDLE, count=0, alu_in all 0, alu_in_len=0, alu_sel=0, alu_set=0, alu_en=0, res_data=0, res_err=0, res_valid=0, cmd_ready=1 on first cycle after release, s_ready=0.
- Reset mid-operation (any state) returns to IDLE immediately; any in-flight result is discarded; no alu_set emitted.
- Command accept → first s_ready: 1 cycle.
- Last element accepted at edge k → alu_set high in cycle k+1 → earliest result capture at edge k+3 (done seen in 2nd WAIT cycle) → res_valid from cycle k+3.
- One element per cycle max in LOAD; s_valid gaps simply stall.
- Single-element vector (s_last on first beat): alu_in_len=0.
- Full vector (N beats, s_last on Nth or absent): alu_in_len=N−1.
- All outputs registered; no combinational path from inputs to outputs except none (cmd_ready, s_ready, res_valid derived from state only).

## Test plan
- Reset: assert rst_n=0 mid-WAIT → all outputs at reset values, state IDLE, cmd_ready=1 after release, no alu_set.
- 4-element max: cmd_sel=2'b11, stream 8'h04, 8'h40, 8'h12, 8'h7F (last) → alu_in[0..3] match, alu_in[4..7]=0, alu_in_len=3, one-cycle alu_set; model returns 8'h7F with done 3 cycles later → res_data=8'h7F, res_err=0.
- Single element: stream 8'hA5 with s_last → alu_in_len=0, alu_set exactly once, result returned.
- Overlength: N=8, stream 10 beats with no s_last → only 8 accepted, s_ready low after 8th, alu_in_len=7.
- Stale done / timeout: hold alu_done=1 throughout → capture occurs on 2nd WAIT cycle, not 1st; then with alu_done=0 forever → res_err=1, res_data=0 after TIMEOUT cycles.
- Backpressure: res_ready=0 for 5 cycles → res_valid and res_data stable, cmd_ready=0; res_ready=1 → IDLE next cycle, new command accepted.

Source files
------------

// File: rtl/reduce_vector_issuer.sv
// Initiator for the vector-reduction ALU: gathers a command and an element stream
// into the ALU operand array, pulses set, waits for done and returns the result.
module reduce_vector_issuer #(
    parameter int BITS    = 8,
    parameter int N       = 8,
    parameter int TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [1:0]      i_cmd_sel,
    input  logic            i_cmd_valid,
    output logic            o_cmd_ready,
    input  logic [BITS-1:0] i_s_data,
    input  logic            i_s_valid,
    input  logic            i_s_last,
    output logic            o_s_ready,
    output logic [BITS-1:0] o_alu_in [N-1:0],
    output logic [7:0]      o_alu_in_len,
    output logic [1:0]      o_alu_sel,
    output logic            o_alu_set,
    output logic            o_alu_en,
    input  logic [BITS-1:0] i_alu_out,
    input  logic            i_alu_done,
    output logic [BITS-1:0] o_res_data,
    output logic            o_res_err,
    output logic            o_res_valid,
    input  logic            i_res_ready
);

    localparam int            TW       = $clog2(TIMEOUT + 1);
    localparam logic [7:0]    LAST_IDX = 8'(N - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_ISSUE = 3'd2,
        S_WAIT  = 3'd3,
        S_RESP  = 3'd4
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [7:0]      r_count;
    logic [TW-1:0]   r_tmo;
    logic [BITS-1:0] r_alu_in [N-1:0];
    logic [7:0]      r_alu_in_len;
    logic [1:0]      r_alu_sel;
    logic [BITS-1:0] r_res_data;
    logic            r_res_err;

    logic w_beat;
    logic w_load_end;
    logic w_done_seen;
    logic w_timeout;

    assign w_beat     = (r_state == S_LOAD) && i_s_valid;
    assign w_load_end = w_beat && (i_s_last || (r_count == LAST_IDX));
    // A done in the first WAIT cycle may be left over from the previous operation.
    assign w_done_seen = (r_state == S_WAIT) && (r_tmo != '0) && i_alu_done;
    assign w_timeout   = (r_state == S_WAIT) && !w_done_seen && (r_tmo == TMO_LAST);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (i_cmd_valid) w_state_nxt = S_LOAD;  else w_state_nxt = S_IDLE;
            S_LOAD:  if (w_load_end)  w_state_nxt = S_ISSUE; else w_state_nxt = S_LOAD;
            S_ISSUE: w_state_nxt = S_WAIT;
            S_WAIT:  if (w_done_seen || w_timeout) w_state_nxt = S_RESP; else w_state_nxt = S_WAIT;
            S_RESP:  if (i_res_ready) w_state_nxt = S_IDLE;  else w_state_nxt = S_RESP;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Handshake and ALU control decoded from the state register only
    always_comb begin
        o_cmd_ready = 1'b0;
        o_s_ready   = 1'b0;
        o_alu_set   = 1'b0;
        o_alu_en    = 1'b0;
        o_res_valid = 1'b0;
        case (r_state)
            S_IDLE:  o_cmd_ready = 1'b1;
            S_LOAD:  o_s_ready   = 1'b1;
            S_ISSUE: begin
                o_alu_set = 1'b1;
                o_alu_en  = 1'b1;
            end
            S_WAIT:  o_alu_en    = 1'b1;
            S_RESP:  o_res_valid = 1'b1;
            default: o_cmd_ready = 1'b0;
        endcase
    end

    // Operand array, length, opcode, timeout counter and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) r_alu_in[i] <= '0;
            r_count      <= 8'd0;
            r_tmo        <= '0;
            r_alu_in_len <= 8'd0;
            r_alu_sel    <= 2'd0;
            r_res_data   <= '0;
            r_res_err    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_cmd_valid) begin
                        r_alu_sel <= i_cmd_sel;
                        r_count   <= 8'd0;
                        for (int i = 0; i < N; i++) r_alu_in[i] <= '0;
                    end
                end
                S_LOAD: begin
                    if (w_beat) begin
                        for (int i = 0; i < N; i++) begin
                            if (r_count == 8'(i)) r_alu_in[i] <= i_s_data;
                        end
                        r_count <= r_count + 8'd1;
                        // Index just written is count-1 after this beat.
                        if (w_load_end) r_alu_in_len <= r_count;
                    end
                end
                S_ISSUE: r_tmo <= '0;
                S_WAIT: begin
                    if (w_done_seen) begin
                        r_res_data <= i_alu_out;
                        r_res_err  <= 1'b0;
                    end else if (w_timeout) begin
                        r_res_data <= '0;
                        r_res_err  <= 1'b1;
                    end else begin
                        r_tmo <= r_tmo + TW'(1);
                    end
                end
                default: r_tmo <= r_tmo;
            endcase
        end
    end

    assign o_alu_in     = r_alu_in;
    assign o_alu_in_len = r_alu_in_len;
    assign o_alu_sel    = r_alu_sel;
    assign o_res_data   = r_res_data;
    assign o_res_err    = r_res_err;

endmodule
